uart_tx_fifo: RTL and testbench

- Byte FIFO plus drain state machine between mmio_peripherals UART TX outputs and the uart core's tx_ena/tx_data/tx_busy inputs.
- Firmware can write a burst of bytes without polling tx_busy per byte.
- The FIFO drains one byte at a time at the UART's pace.
- Sticky status flags report overflow and failed starts.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo_mem.sv | 36 +++
 rtl/uart_tx_fifo.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART TX byte FIFO slice.
//   BYTE_W            - width of one queued byte
//   DEF_DEPTH_BITS    - default log2 FIFO depth
//   DEF_START_TIMEOUT - default cycles allowed for tx_busy to rise after tx_ena
//   drain_state_e     - 2-bit drain FSM encoding
package uart_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned DEF_DEPTH_BITS    = 4;
  localparam int unsigned DEF_START_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// uart_tx_fifo_mem: simple dual-port byte array, synchronous write and
// asynchronous read, contents not reset (maps onto an iCE40 BRAM later).
//   clk     - write clock
//   wr_en   - write strobe
//   wr_addr - write address
//   wr_data - write byte
//   rd_addr - read address
//   rd_data - byte at rd_addr (combinational)
module uart_tx_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_BITS = DEF_DEPTH_BITS
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_BITS-1:0] wr_addr,
  input  logic [BYTE_W-1:0]     wr_data,
  input  logic [DEPTH_BITS-1:0] rd_addr,
  output logic [BYTE_W-1:0]     rd_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  logic [BYTE_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus drain FSM feeding the UART core one byte at a
// time. Firmware pushes bursts; the FSM pops when the core is not busy,
// pulses tx_ena for one cycle and waits for tx_busy to rise and fall.
// Optional build macro: UART_TX_FIFO_STATS_EN adds high_water / drop_count.
//   clk         - system clock
//   reset       - asynchronous active-high reset
//   wr_en       - push strobe, wr_data - byte to push
//   flush       - discard all queued bytes (in-flight byte still completes)
//   err_clr     - clear sticky flags (a same-cycle set wins)
//   tx_busy     - UART core busy
//   tx_ena      - one-cycle start strobe, tx_data - byte to send
//   full/empty/count - FIFO occupancy
//   idle        - nothing queued, FSM idle and core not busy
//   overflow    - sticky, a push was dropped
//   timeout_err - sticky, tx_busy never rose after tx_ena
//   high_water  - (stats) max count since reset or err_clr
//   drop_count  - (stats) saturating dropped-push count
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_BITS    = DEF_DEPTH_BITS,
  parameter int unsigned START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [BYTE_W-1:0]     wr_data,
  input  logic                  flush,
  input  logic                  err_clr,
  input  logic                  tx_busy,
  output logic                  tx_ena,
  output logic [BYTE_W-1:0]     tx_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   count,
  output logic                  idle,
  output logic                  overflow,
  output logic                  timeout_err
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic [DEPTH_BITS:0]   high_water,
  output logic [15:0]           drop_count
`endif
);

  localparam int unsigned CNT_W   = DEPTH_BITS + 1;
  localparam int unsigned DEPTH   = 1 << DEPTH_BITS;
  localparam int unsigned TO_W    = $clog2(START_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

  drain_state_e          state;
  drain_state_e          state_nxt;
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [CNT_W-1:0]      count_nxt;
  logic [TO_W-1:0]       to_cnt;
  logic [TO_W-1:0]       to_cnt_nxt;
  logic [TO_W-1:0]       to_cnt_inc;
  logic [BYTE_W-1:0]     rd_byte;
  logic                  push_c;
  logic                  drop_c;
  logic                  pop_c;
  logic                  to_expire_c;

  // Occupancy decode from the registered count
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign idle  = empty && (state == IDLE) && !tx_busy;

  // flush swallows a same-cycle write without flagging it as dropped
  assign push_c = wr_en && !full && !flush;
  assign drop_c = wr_en &&  full && !flush;

  assign to_cnt_inc = to_cnt + TO_W'(1);

  uart_tx_fifo_mem #(
    .DEPTH_BITS (DEPTH_BITS)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_c),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_byte)
  );

  // Drain FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (pop_c) state_nxt = ISSUE;
      ISSUE:      state_nxt = WAIT_START;
      WAIT_START: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_expire_c) begin
          state_nxt = IDLE;
        end
      end
      WAIT_DONE:  if (!tx_busy) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Drain FSM outputs: pop strobe and start-timeout bookkeeping
  always_comb begin
    pop_c       = 1'b0;
    to_expire_c = 1'b0;
    to_cnt_nxt  = to_cnt;
    case (state)
      IDLE:  pop_c = !empty && !tx_busy && !flush;
      ISSUE: to_cnt_nxt = '0;
      WAIT_START: begin
        if (tx_busy) begin
          to_cnt_nxt = '0;
        end else begin
          to_cnt_nxt  = to_cnt_inc;
          to_expire_c = (to_cnt_inc == TO_LAST);
        end
      end
      default: ;
    endcase
  end

  // Next occupancy; a simultaneous push and pop cancel out
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push_c, pop_c})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Pointers and count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
        if (pop_c)  rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      end
    end
  end

  // UART-side outputs; tx_data holds the loaded byte until the next pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ena  <= 1'b0;
      tx_data <= '0;
      to_cnt  <= '0;
    end else begin
      tx_ena <= (state_nxt == ISSUE);
      to_cnt <= to_cnt_nxt;
      if (pop_c) begin
        tx_data <= rd_byte;
      end
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (to_expire_c) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

`ifdef UART_TX_FIFO_STATS_EN
  // Occupancy high-water mark and saturating drop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_water <= '0;
      drop_count <= '0;
    end else begin
      if (err_clr) begin
        high_water <= count_nxt;
      end else if (count_nxt > high_water) begin
        high_water <= count_nxt;
      end
      if (drop_c) begin
        if (err_clr) begin
          drop_count <= 16'd1;
        end else if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end else if (err_clr) begin
        drop_count <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed, self-checking bench for uart_tx_fifo with a
// behavioural UART busy model (rises one cycle after tx_ena, holds for a
// programmable frame length). Also covers the stats outputs when
// UART_TX_FIFO_STATS_EN is defined.
module tb_uart_tx_fifo;

  localparam int BM_MODEL = 0;
  localparam int BM_HI    = 1;
  localparam int BM_NEVER = 2;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       err_clr;
  logic       tx_busy;
  logic       tx_ena;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       idle;
  logic       overflow;
  logic       timeout_err;
`ifdef UART_TX_FIFO_STATS_EN
  logic [4:0]  high_water;
  logic [15:0] drop_count;
`endif

  uart_tx_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .flush       (flush),
    .err_clr     (err_clr),
    .tx_busy     (tx_busy),
    .tx_ena      (tx_ena),
    .tx_data     (tx_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .idle        (idle),
    .overflow    (overflow),
    .timeout_err (timeout_err)
`ifdef UART_TX_FIFO_STATS_EN
    ,
    .high_water  (high_water),
    .drop_count  (drop_count)
`endif
  );

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       err_clr;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;

  int         checks;
  int         errors;
  int         busy_mode;
  int         frame_len;
  int         busy_left;
  bit         busy_pend;
  int         ena_count;
  int         max_cnt;
  logic [7:0] tx_log [$];
  vec_t       vecs [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // UART core model; runs at +2 so the main thread (+1) sees stable values
  initial begin
    tx_busy   = 1'b0;
    busy_pend = 1'b0;
    busy_left = 0;
    ena_count = 0;
    forever begin
      @(posedge clk);
      #2;
      if (tx_ena === 1'b1) begin
        ena_count++;
        tx_log.push_back(tx_data);
      end
      if (int'(count) > max_cnt) max_cnt = int'(count);
      case (busy_mode)
        BM_HI: begin
          tx_busy = 1'b1; busy_pend = 1'b0; busy_left = 0;
        end
        BM_NEVER: begin
          tx_busy = 1'b0; busy_pend = 1'b0; busy_left = 0;
        end
        default: begin
          if (busy_pend) begin
            tx_busy   = 1'b1;
            busy_left = frame_len;
            busy_pend = 1'b0;
          end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
          end else begin
            tx_busy = 1'b0;
          end
          if (tx_ena === 1'b1) busy_pend = 1'b1;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_ena(input string name, input int max_cyc);
    int n = 0;
    while (tx_ena !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    chk(name, 32'(tx_ena), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (idle !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    chk(name, 32'(idle), 32'd1);
  endtask

  function automatic vec_t mk(input logic we, input logic [7:0] d, input logic fl,
                              input logic ec, input logic [4:0] c, input logic f,
                              input logic e, input logic o);
    vec_t v;
    v.wr_en = we; v.wr_data = d; v.flush = fl; v.err_clr = ec;
    v.exp_count = c; v.exp_full = f; v.exp_empty = e; v.exp_ovf = o;
    return v;
  endfunction

  initial begin
    int ena_before;
    int n;
    int sizes [3];
    logic [7:0] nb;

    checks    = 0;
    errors    = 0;
    busy_mode = BM_NEVER;
    frame_len = 10;
    max_cnt   = 0;

    // Table: fill to full with the core stuck busy, overflow, err_clr races, flush
    for (int i = 0; i < 16; i++) begin
      vecs.push_back(mk(1'b1, 8'(i), 1'b0, 1'b0, 5'(i + 1), (i == 15), 1'b0, 1'b0));
    end
    vecs.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1)); // dropped
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0)); // clear
    vecs.push_back(mk(1'b1, 8'hEE, 1'b0, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1)); // set wins
    vecs.push_back(mk(1'b1, 8'hDD, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1)); // flush wins
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 8'h77, 1'b0, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0));

    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; err_clr = 1'b0;
    step(); step(); step();
    reset = 1'b0;

    // Reset values
    chk("rst_tx_ena",  32'(tx_ena), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_count",   32'(count), 32'd0);
    chk("rst_full",    32'(full), 32'd0);
    chk("rst_empty",   32'(empty), 32'd1);
    chk("rst_idle",    32'(idle), 32'd1);
    chk("rst_ovf",     32'(overflow), 32'd0);
    chk("rst_to",      32'(timeout_err), 32'd0);

    // Single byte: tx_ena two cycles after the push
    busy_mode  = BM_MODEL;
    frame_len  = 10;
    tx_log.delete();
    ena_before = ena_count;
    push(8'h41);
    chk("single_count_n1", 32'(count), 32'd1);
    chk("single_ena_n1",   32'(tx_ena), 32'd0);
    step();
    chk("single_ena_n2",   32'(tx_ena), 32'd1);
    chk("single_data_n2",  32'(tx_data), 32'h41);
    chk("single_count_n2", 32'(count), 32'd0);
    chk("single_idle_n2",  32'(idle), 32'd0);
    step();
    chk("single_ena_n3",   32'(tx_ena), 32'd0);
    wait_idle("single_idle_wait", 60);
    chk("single_ena_pulses", 32'(ena_count - ena_before), 32'd1);
    chk("single_data_held",  32'(tx_data), 32'h41);

    // Table-driven FIFO occupancy with the core stuck busy (no pops)
    busy_mode = BM_HI;
    step(); step();
    for (int i = 0; i < vecs.size(); i++) begin
      wr_en   = vecs[i].wr_en;
      wr_data = vecs[i].wr_data;
      flush   = vecs[i].flush;
      err_clr = vecs[i].err_clr;
      step();
      wr_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
      chk($sformatf("vec%0d_count", i), 32'(count),    32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_full", i),  32'(full),     32'(vecs[i].exp_full));
      chk($sformatf("vec%0d_empty", i), 32'(empty),    32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_ovf", i),   32'(overflow), 32'(vecs[i].exp_ovf));
    end
    chk("table_no_ena", 32'(tx_ena), 32'd0);

    // Timeout: core never goes busy
    busy_mode = BM_NEVER;
    step(); step();
    push(8'hA5);
    wait_ena("to_ena", 10);
    chk("to_data", 32'(tx_data), 32'hA5);
    for (int j = 1; j <= 15; j++) step();
    chk("to_flag_c15", 32'(timeout_err), 32'd0);
    step();
    chk("to_flag_c16", 32'(timeout_err), 32'd1);
    chk("to_idle_c16", 32'(idle), 32'd1);
    busy_mode = BM_MODEL;
    frame_len = 6;
    push(8'h5A);
    wait_ena("to_next_ena", 10);
    chk("to_next_data", 32'(tx_data), 32'h5A);
    wait_idle("to_next_idle", 60);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_cleared", 32'(timeout_err), 32'd0);

    // Burst across pointer wrap, slow core
    frame_len = 20;
    tx_log.delete();
    max_cnt = 0;
    sizes[0] = 8; sizes[1] = 8; sizes[2] = 4;
    n = 0;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < sizes[f]; b++) begin
        push(8'(n));
        n++;
      end
      wait_idle($sformatf("burst_fill%0d_idle", f), 400);
    end
    chk("burst_len", 32'(tx_log.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      nb = (i < tx_log.size()) ? tx_log[i] : 8'hXX;
      chk($sformatf("burst_byte%0d", i), 32'(nb), 32'(i));
    end
    chk("burst_max_le16", 32'(max_cnt <= 16), 32'd1);
    chk("burst_ovf", 32'(overflow), 32'd0);

    // Flush while first byte is in WAIT_DONE
    tx_log.delete();
    ena_before = ena_count;
    for (int b = 0; b < 5; b++) push(8'(8'h60 + b));
    n = 0;
    while (tx_busy !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("flush_busy_seen", 32'(tx_busy), 32'd1);
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    wait_idle("flush_idle", 100);
    for (int j = 0; j < 30; j++) step();
    chk("flush_ena_pulses", 32'(ena_count - ena_before), 32'd1);
    nb = (tx_log.size() > 0) ? tx_log[0] : 8'hXX;
    chk("flush_byte1", 32'(nb), 32'h60);

    // Overflow with stuck-busy core, then reset in the middle of ISSUE
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    busy_mode = BM_HI;
    step(); step();
    for (int b = 0; b < 17; b++) push(8'(8'h80 + b));
    chk("ovf_full",  32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_flag",  32'(overflow), 32'd1);
`ifdef UART_TX_FIFO_STATS_EN
    chk("ovf_drop_count", 32'(drop_count), 32'd1);
    chk("ovf_high_water", 32'(high_water), 32'd16);
`endif
    busy_mode = BM_MODEL;
    wait_ena("rst_mid_ena", 10);
    chk("rst_mid_data", 32'(tx_data), 32'h80);
    reset = 1'b1;
    #1;
    chk("rst_mid_tx_ena",  32'(tx_ena), 32'd0);
    chk("rst_mid_tx_data", 32'(tx_data), 32'h00);
    chk("rst_mid_count",   32'(count), 32'd0);
    chk("rst_mid_ovf",     32'(overflow), 32'd0);
    chk("rst_mid_to",      32'(timeout_err), 32'd0);
    chk("rst_mid_empty",   32'(empty), 32'd1);
    busy_mode = BM_NEVER;
    step(); step();
    reset = 1'b0;
    step();
    chk("post_rst_idle", 32'(idle), 32'd1);
    chk("post_rst_ena",  32'(tx_ena), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
